// File: rtl/i2c_master_pkg.sv
// Shared types, phase/slot constants and bus-level helpers for the I2C initiator.
package i2c_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam int unsigned NUM_SLOTS = 9;
    localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);

    // SDA level the initiator drives in a bit slot: data MSB first, ACK slot last.
    function automatic logic slot_bit(input logic is_write, input logic [7:0] data,
                                      input logic ack, input logic [3:0] slot);
        logic [2:0] idx;
        idx = 3'(4'd7 - slot);
        if (slot < 4'd8) begin
            return is_write ? data[idx] : 1'b1;
        end
        return is_write ? 1'b1 : ack;
    endfunction

    // {scl, sda} drive for a given sub-operation phase.
    function automatic logic [1:0] bus_level(input state_t st, input logic [1:0] ph,
                                             input logic bitv, input logic scl_cur);
        logic [1:0] lv;
        lv = {scl_cur, 1'b1};
        case (st)
            ST_START: begin
                case (ph)
                    PH0:     lv = {scl_cur, 1'b1};
                    PH1:     lv = 2'b11;
                    PH2:     lv = 2'b10;
                    default: lv = 2'b00;
                endcase
            end
            ST_BIT: begin
                lv = {(ph == PH1) || (ph == PH2), bitv};
            end
            ST_STOP: begin
                case (ph)
                    PH0:     lv = 2'b00;
                    PH1:     lv = 2'b10;
                    default: lv = 2'b11;
                endcase
            end
            default: lv = {scl_cur, 1'b1};
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period tick generator; held at zero while a target stretches SCL.
module i2c_qtick #(
    parameter int unsigned DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !hold && (cnt == LAST);

    // Count 0..DIV-1 while enabled; clear when idle or stretched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || hold) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C initiator: START / byte write / byte read / STOP on open-drain lines.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int unsigned DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic [7:0] wr_data,
    input  logic       rd_ack,
    output logic [7:0] rd_data,
    output logic       ack_rcvd,
    output logic       done,
    output logic       busy,
    output logic       scl_o,
    input  logic       scl_i,
    output logic       sda_o,
    input  logic       sda_i
);

    state_t     state;
    logic [1:0] phase;
    logic [3:0] slot;
    logic       q_byte;
    logic       q_write;
    logic       q_stop;
    logic [7:0] q_data;
    logic       q_ack;
    logic       sample_pend;
    logic       tick;
    logic       tick_en;
    logic       hold;
    logic       cur_bit;
    logic       next_bit;

    assign tick_en  = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);
    assign hold     = scl_o && !scl_i;
    assign cur_bit  = slot_bit(q_write, q_data, q_ack, slot);
    assign next_bit = slot_bit(q_write, q_data, q_ack, slot + 4'd1);

    i2c_qtick #(.DIV(DIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .hold (hold),
        .tick (tick)
    );

    // Command sequencer: START -> byte -> STOP, one phase per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= PH0;
            slot        <= '0;
            q_byte      <= 1'b0;
            q_write     <= 1'b0;
            q_stop      <= 1'b0;
            q_data      <= '0;
            q_ack       <= 1'b0;
            sample_pend <= 1'b0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b0;
            rd_data     <= '0;
            ack_rcvd    <= 1'b0;
            scl_o       <= 1'b1;
            sda_o       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        q_byte    <= cmd_write || cmd_read;
                        q_write   <= cmd_write;
                        q_stop    <= cmd_stop;
                        q_data    <= wr_data;
                        q_ack     <= rd_ack;
                        phase     <= PH0;
                        slot      <= '0;
                        if (cmd_start) begin
                            state          <= ST_START;
                            {scl_o, sda_o} <= bus_level(ST_START, PH0, 1'b1, scl_o);
                        end else if (cmd_write || cmd_read) begin
                            state          <= ST_BIT;
                            {scl_o, sda_o} <= bus_level(ST_BIT, PH0,
                                              slot_bit(cmd_write, wr_data, rd_ack, 4'd0), scl_o);
                        end else if (cmd_stop) begin
                            state          <= ST_STOP;
                            {scl_o, sda_o} <= bus_level(ST_STOP, PH0, 1'b0, scl_o);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    if ((state == ST_BIT) && (phase == PH2) && sample_pend) begin
                        sample_pend <= 1'b0;
                        if (slot == LAST_SLOT) begin
                            if (q_write) ack_rcvd <= sda_i;
                        end else if (!q_write) begin
                            rd_data <= {rd_data[6:0], sda_i};
                        end
                    end
                    if (tick) begin
                        if (phase != PH3) begin
                            phase          <= phase + 2'd1;
                            {scl_o, sda_o} <= bus_level(state, phase + 2'd1, cur_bit, scl_o);
                            if (phase == PH1) begin
                                if (state == ST_START) busy <= 1'b1;
                                if (state == ST_BIT) sample_pend <= 1'b1;
                            end
                        end else begin
                            phase <= PH0;
                            case (state)
                                ST_START: begin
                                    if (q_byte) begin
                                        state          <= ST_BIT;
                                        slot           <= '0;
                                        {scl_o, sda_o} <= bus_level(ST_BIT, PH0,
                                                          slot_bit(q_write, q_data, q_ack, 4'd0), scl_o);
                                    end else if (q_stop) begin
                                        state          <= ST_STOP;
                                        {scl_o, sda_o} <= bus_level(ST_STOP, PH0, 1'b0, scl_o);
                                    end else begin
                                        state <= ST_DONE;
                                    end
                                end
                                ST_BIT: begin
                                    if (slot != LAST_SLOT) begin
                                        slot           <= slot + 4'd1;
                                        {scl_o, sda_o} <= bus_level(ST_BIT, PH0, next_bit, scl_o);
                                    end else if (q_stop) begin
                                        state          <= ST_STOP;
                                        {scl_o, sda_o} <= bus_level(ST_STOP, PH0, 1'b0, scl_o);
                                    end else begin
                                        state <= ST_DONE;
                                    end
                                end
                                default: begin
                                    busy  <= 1'b0;
                                    state <= ST_DONE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
